// File: rtl/i2c_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_pkg
//  Description : Shared I2C definitions: address/data widths, the request
//                arbiter state encoding and the default 2 ms timeout at
//                12 MHz.
//  Revision    : 1.0 - initial release
// ============================================================================
package i2c_pkg;

    localparam int I2C_ADDR_W        = 7;
    localparam int I2C_DATA_W        = 8;
    localparam int TIMEOUT_12MHZ_2MS = 24000;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ISSUE     = 3'd1,
        WAIT_BUSY = 3'd2,
        WAIT_DONE = 3'd3,
        RESP      = 3'd4
    } arb_state_t;

endpackage : i2c_pkg
`default_nettype wire

// File: rtl/i2c_req_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_req_arbiter_if
//  Description : Command/response bus between the request arbiter and the
//                single I2C master engine.
//                  master modport : arbiter side (drives start + payload)
//                  slave  modport : I2C engine side (drives busy/done/result)
//                  m_start  1-cycle start pulse      m_busy  engine busy
//                  m_addr   7-bit slave address      m_done  1-cycle done
//                  m_rw     1 = read, 0 = write      m_rdata read byte
//                  m_wdata  write byte               m_nack  slave NACK
//  Revision    : 1.0 - initial release
// ============================================================================
interface i2c_req_arbiter_if;
    import i2c_pkg::*;

    logic                  m_start;
    logic [I2C_ADDR_W-1:0] m_addr;
    logic                  m_rw;
    logic [I2C_DATA_W-1:0] m_wdata;
    logic                  m_busy;
    logic                  m_done;
    logic [I2C_DATA_W-1:0] m_rdata;
    logic                  m_nack;

    modport master (
        output m_start, m_addr, m_rw, m_wdata,
        input  m_busy, m_done, m_rdata, m_nack
    );

    modport slave (
        input  m_start, m_addr, m_rw, m_wdata,
        output m_busy, m_done, m_rdata, m_nack
    );

endinterface : i2c_req_arbiter_if
`default_nettype wire

// File: rtl/i2c_req_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick
//  Description : Combinational rotating-priority encoder. Returns the first
//                set request bit found searching upward from ptr, wrapping
//                modulo N_REQ.
//                  req : request vector        win : winning index
//                  ptr : highest-priority idx  any : at least one request
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
    parameter int N_REQ = 2,
    parameter int IDX_W = 1
) (
    input  wire logic [N_REQ-1:0] req,
    input  wire logic [IDX_W-1:0] ptr,
    output logic      [IDX_W-1:0] win,
    output logic                  any
);

    always_comb begin
        int w_j;
        w_j = 0;
        win = '0;
        any = |req;
        // Walk offsets from farthest to nearest so the nearest set bit to ptr
        // is the last (and therefore winning) assignment.
        for (int i = N_REQ - 1; i >= 0; i--) begin
            w_j = int'(ptr) + i;
            if (w_j >= N_REQ) begin
                w_j = w_j - N_REQ;
            end
            if (req[w_j]) begin
                win = IDX_W'(w_j);
            end
        end
    end

endmodule : rr_pick
`default_nettype wire

// File: rtl/i2c_req_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_req_arbiter
//  Description : Round-robin arbiter sharing one I2C master between N_REQ
//                requesters, one byte transaction per grant, each bounded by
//                a TIMEOUT_CYC timeout.
//                  req/req_addr/req_rw/req_wdata : per-requester request+payload
//                  gnt  : one-hot grant, held for the whole transaction
//                  done : one-cycle completion pulse on the granted index
//                  rdata/nack : result, valid while done is high
//                  timeout_err : sticky timeout flag (reset only)
//                  bus  : command/response bus to the I2C master engine
//  Revision    : 1.0 - initial release
// ============================================================================
module i2c_req_arbiter
    import i2c_pkg::*;
#(
    parameter int N_REQ       = 2,
    parameter int TIMEOUT_CYC = TIMEOUT_12MHZ_2MS,
    parameter int TO_W        = 15
) (
    input  wire logic                          clk,
    input  wire logic                          rst_n,
    input  wire logic [N_REQ-1:0]              req,
    input  wire logic [I2C_ADDR_W*N_REQ-1:0]   req_addr,
    input  wire logic [N_REQ-1:0]              req_rw,
    input  wire logic [I2C_DATA_W*N_REQ-1:0]   req_wdata,
    output logic      [N_REQ-1:0]              gnt,
    output logic      [N_REQ-1:0]              done,
    output logic      [I2C_DATA_W-1:0]         rdata,
    output logic                               nack,
    output logic                               timeout_err,
    i2c_req_arbiter_if.master                  bus
);

    localparam int              IDX_W     = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [TO_W-1:0] C_TO_LAST = TO_W'(TIMEOUT_CYC - 1);

    arb_state_t       r_state;
    logic [IDX_W-1:0] r_rr_ptr;
    logic [IDX_W-1:0] r_win;
    logic [TO_W-1:0]  r_cnt;

    logic [IDX_W-1:0] w_win;
    logic             w_any;
    logic [IDX_W-1:0] w_next_ptr;

    function automatic logic [N_REQ-1:0] f_onehot(input logic [IDX_W-1:0] idx);
        logic [N_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req (req),
        .ptr (r_rr_ptr),
        .win (w_win),
        .any (w_any)
    );

    assign w_next_ptr = (r_win == IDX_W'(N_REQ - 1)) ? '0 : r_win + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_rr_ptr     <= '0;
            r_win        <= '0;
            r_cnt        <= '0;
            gnt          <= '0;
            done         <= '0;
            rdata        <= '0;
            nack         <= 1'b0;
            timeout_err  <= 1'b0;
            bus.m_start  <= 1'b0;
            bus.m_addr   <= '0;
            bus.m_rw     <= 1'b0;
            bus.m_wdata  <= '0;
        end else begin
            bus.m_start <= 1'b0;
            done        <= '0;
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        // Payload is captured here so requester changes after
                        // the grant cannot disturb the bus transaction.
                        r_win       <= w_win;
                        gnt         <= f_onehot(w_win);
                        bus.m_addr  <= req_addr[w_win*I2C_ADDR_W +: I2C_ADDR_W];
                        bus.m_rw    <= req_rw[w_win];
                        bus.m_wdata <= req_wdata[w_win*I2C_DATA_W +: I2C_DATA_W];
                        r_state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    bus.m_start <= 1'b1;
                    r_cnt       <= '0;
                    r_state     <= WAIT_BUSY;
                end
                WAIT_BUSY, WAIT_DONE: begin
                    r_cnt <= r_cnt + 1'b1;
                    // A master fast enough to finish before busy is seen is
                    // accepted in WAIT_BUSY too; completion beats timeout.
                    if (bus.m_done) begin
                        rdata   <= bus.m_rdata;
                        nack    <= bus.m_nack;
                        done    <= f_onehot(r_win);
                        r_state <= RESP;
                    end else if (r_cnt == C_TO_LAST) begin
                        rdata       <= '0;
                        nack        <= 1'b1;
                        timeout_err <= 1'b1;
                        done        <= f_onehot(r_win);
                        r_state     <= RESP;
                    end else if ((r_state == WAIT_BUSY) && bus.m_busy) begin
                        r_state <= WAIT_DONE;
                    end
                end
                RESP: begin
                    gnt      <= '0;
                    r_rr_ptr <= w_next_ptr;
                    r_state  <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule : i2c_req_arbiter
`default_nettype wire

// File: tb/tb_i2c_req_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_i2c_req_arbiter
//  Description : Self-checking bench for i2c_req_arbiter: vector table of
//                single transactions plus directed contention, timeout and
//                mid-transaction reset sequences against a simple I2C master
//                model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_i2c_req_arbiter;

    localparam int N_REQ       = 2;
    localparam int TIMEOUT_CYC = 24000;

    logic        clk;
    logic        rst_n;
    logic [1:0]  req;
    logic [13:0] req_addr;
    logic [1:0]  req_rw;
    logic [15:0] req_wdata;
    logic [1:0]  gnt;
    logic [1:0]  done;
    logic [7:0]  rdata;
    logic        nack;
    logic        timeout_err;

    i2c_req_arbiter_if bus ();

    i2c_req_arbiter #(
        .N_REQ       (N_REQ),
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .TO_W        (15)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .req_addr    (req_addr),
        .req_rw      (req_rw),
        .req_wdata   (req_wdata),
        .gnt         (gnt),
        .done        (done),
        .rdata       (rdata),
        .nack        (nack),
        .timeout_err (timeout_err),
        .bus         (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- I2C master model ----------------
    logic       mdl_hang;
    int         mdl_busy_cyc;
    logic [7:0] mdl_rd;
    logic       mdl_nk;
    logic       mdl_busy;
    logic       mdl_done;
    logic       late_done;

    assign bus.m_busy  = mdl_busy;
    assign bus.m_done  = mdl_done | late_done;
    assign bus.m_rdata = late_done ? 8'hFF : (mdl_done ? mdl_rd : 8'h99);
    assign bus.m_nack  = late_done ? 1'b0 : (mdl_done & mdl_nk);

    initial begin
        mdl_busy = 1'b0;
        mdl_done = 1'b0;
    end

    always begin
        @(negedge clk);
        if (rst_n && bus.m_start && !mdl_hang) begin
            mdl_busy = 1'b1;
            for (int k = 0; k < mdl_busy_cyc && rst_n; k++) @(negedge clk);
            mdl_busy = 1'b0;
            if (rst_n) begin
                mdl_done = 1'b1;
                @(negedge clk);
                mdl_done = 1'b0;
            end
        end
    end

    // ---------------- monitor ----------------
    int start_cnt;
    int inv_err;
    initial begin
        start_cnt = 0;
        inv_err   = 0;
    end
    always @(negedge clk) begin
        if (bus.m_start) start_cnt++;
        if (!$onehot0(gnt)) inv_err++;
        if ((done & ~gnt) != 2'b00) inv_err++;
        if (!$onehot0(done)) inv_err++;
    end

    // ---------------- checking ----------------
    int n_total;
    int n_pass;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, exp);
    endtask

    typedef struct {
        logic [1:0] rq;
        logic [6:0] a0, a1;
        logic [1:0] rw;
        logic [7:0] d0, d1;
        logic [7:0] mrd;
        logic       mnk;
        logic       drop;
        int         win;
        logic [6:0] eaddr;
        logic       erw;
        logic [7:0] ewd;
        logic [7:0] erd;
        logic       enk;
        logic       eto;
    } vec_t;

    vec_t vecs[6];
    vec_t vx;

    task automatic run_txn(input vec_t v, input string tag);
        logic [1:0] eoh;
        logic       got;
        eoh = (v.win == 1) ? 2'b10 : 2'b01;
        @(negedge clk);
        req_addr  = {v.a1, v.a0};
        req_wdata = {v.d1, v.d0};
        req_rw    = v.rw;
        mdl_rd    = v.mrd;
        mdl_nk    = v.mnk;
        req       = v.rq;
        @(negedge clk);
        check({tag, " gnt+1"}, gnt, eoh);
        check({tag, " no early start"}, bus.m_start, 1'b0);
        @(negedge clk);
        check({tag, " m_start+2"}, bus.m_start, 1'b1);
        check({tag, " m_addr"}, bus.m_addr, v.eaddr);
        check({tag, " m_rw"}, bus.m_rw, v.erw);
        check({tag, " m_wdata"}, bus.m_wdata, v.ewd);
        // Payload changes after the grant must be ignored.
        req_addr  = ~req_addr;
        req_wdata = ~req_wdata;
        req_rw    = ~req_rw;
        if (v.drop) req = 2'b00;
        got = 1'b0;
        for (int k = 0; k < 100 && !got; k++) begin
            @(negedge clk);
            if (done != 2'b00) got = 1'b1;
        end
        check({tag, " done seen"}, got, 1'b1);
        check({tag, " done idx"}, done, eoh);
        check({tag, " rdata"}, rdata, v.erd);
        check({tag, " nack"}, nack, v.enk);
        check({tag, " timeout_err"}, timeout_err, v.eto);
        check({tag, " m_addr held"}, bus.m_addr, v.eaddr);
        req = 2'b00;
        @(negedge clk);
        check({tag, " done 1 cyc"}, done, 2'b00);
        check({tag, " gnt clear"}, gnt, 2'b00);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       got;
        logic       bad;
        int         cnt;
        int         s0;
        n_total      = 0;
        n_pass       = 0;
        rst_n        = 1'b0;
        req          = 2'b00;
        req_addr     = '0;
        req_rw       = 2'b00;
        req_wdata    = '0;
        mdl_hang     = 1'b0;
        mdl_busy_cyc = 2;
        mdl_rd       = 8'h00;
        mdl_nk       = 1'b0;
        late_done    = 1'b0;

        //          rq     a0     a1     rw     d0     d1     mrd    mnk   drop win eaddr  erw  ewd    erd    enk   eto
        vecs[0] = '{2'b01, 7'h48, 7'h00, 2'b00, 8'hA5, 8'h00, 8'h00, 1'b0, 1'b0, 0, 7'h48, 1'b0, 8'hA5, 8'h00, 1'b0, 1'b0};
        vecs[1] = '{2'b10, 7'h00, 7'h50, 2'b10, 8'h00, 8'h00, 8'h3C, 1'b0, 1'b0, 1, 7'h50, 1'b1, 8'h00, 8'h3C, 1'b0, 1'b0};
        vecs[2] = '{2'b01, 7'h21, 7'h00, 2'b00, 8'h5A, 8'h00, 8'h00, 1'b1, 1'b0, 0, 7'h21, 1'b0, 8'h5A, 8'h00, 1'b1, 1'b0};
        vecs[3] = '{2'b01, 7'h7F, 7'h00, 2'b01, 8'h00, 8'h00, 8'hC3, 1'b0, 1'b1, 0, 7'h7F, 1'b1, 8'h00, 8'hC3, 1'b0, 1'b0};
        vecs[4] = '{2'b11, 7'h12, 7'h6B, 2'b01, 8'h11, 8'hE7, 8'h00, 1'b0, 1'b0, 1, 7'h6B, 1'b0, 8'hE7, 8'h00, 1'b0, 1'b0};
        vecs[5] = '{2'b11, 7'h12, 7'h6B, 2'b01, 8'h11, 8'hE7, 8'h9E, 1'b0, 1'b0, 0, 7'h12, 1'b1, 8'h11, 8'h9E, 1'b0, 1'b0};

        // Reset state
        repeat (2) @(negedge clk);
        check("rst gnt", gnt, 2'b00);
        check("rst done", done, 2'b00);
        check("rst rdata", rdata, 8'h00);
        check("rst nack", nack, 1'b0);
        check("rst timeout_err", timeout_err, 1'b0);
        check("rst m_start", bus.m_start, 1'b0);
        check("rst m_payload", {bus.m_addr, bus.m_rw, bus.m_wdata}, 16'h0000);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

        // Contention: both requesting continuously from reset.
        @(negedge clk);
        rst_n     = 1'b0;
        req_addr  = {7'h30, 7'h40};
        req_wdata = {8'h22, 8'h11};
        req_rw    = 2'b00;
        req       = 2'b11;
        @(negedge clk);
        s0    = start_cnt;
        rst_n = 1'b1;
        for (int g = 0; g < 4; g++) begin
            got = 1'b0;
            for (int k = 0; k < 100 && !got; k++) begin
                @(negedge clk);
                if (done != 2'b00) got = 1'b1;
            end
            check($sformatf("contend done seen %0d", g), got, 1'b1);
            check($sformatf("contend order %0d", g), done, (g % 2 == 0) ? 2'b01 : 2'b10);
        end
        req = 2'b00;
        check("contend start count", start_cnt - s0, 4);
        repeat (2) @(negedge clk);

        // Timeout: master never raises busy.
        mdl_hang = 1'b1;
        req_addr = {7'h00, 7'h33};
        req_rw   = 2'b01;
        req      = 2'b01;
        got = 1'b0;
        for (int k = 0; k < 10 && !got; k++) begin
            @(negedge clk);
            if (bus.m_start) got = 1'b1;
        end
        check("to m_start seen", got, 1'b1);
        got = 1'b0;
        cnt = 0;
        while (cnt < TIMEOUT_CYC + 10 && !got) begin
            @(negedge clk);
            cnt++;
            if (done != 2'b00) got = 1'b1;
        end
        check("to done seen", got, 1'b1);
        check("to latency", cnt, TIMEOUT_CYC);
        check("to done idx", done, 2'b01);
        check("to nack", nack, 1'b1);
        check("to rdata", rdata, 8'h00);
        check("to timeout_err", timeout_err, 1'b1);
        req = 2'b00;
        @(negedge clk);
        late_done = 1'b1;
        @(negedge clk);
        late_done = 1'b0;
        bad = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (done != 2'b00 || gnt != 2'b00) bad = 1'b1;
        end
        check("late m_done ignored", bad, 1'b0);
        check("to sticky", timeout_err, 1'b1);
        mdl_hang = 1'b0;

        vx = '{2'b10, 7'h00, 7'h0F, 2'b00, 8'h00, 8'h3E, 8'h00, 1'b0, 1'b0, 1, 7'h0F, 1'b0, 8'h3E, 8'h00, 1'b0, 1'b1};
        run_txn(vx, "sticky");

        // Reset while the master is mid-transaction.
        mdl_busy_cyc = 20;
        @(negedge clk);
        req_addr = {7'h11, 7'h00};
        req_rw   = 2'b00;
        req      = 2'b10;
        got = 1'b0;
        for (int k = 0; k < 10 && !got; k++) begin
            @(negedge clk);
            if (bus.m_start) got = 1'b1;
        end
        check("rstmid m_start seen", got, 1'b1);
        repeat (3) @(negedge clk);
        check("rstmid gnt before", gnt, 2'b10);
        #2;
        rst_n = 1'b0;
        #1;
        check("rstmid gnt", gnt, 2'b00);
        check("rstmid m_start", bus.m_start, 1'b0);
        check("rstmid m_addr", bus.m_addr, 7'h00);
        check("rstmid timeout_err", timeout_err, 1'b0);
        req = 2'b00;
        mdl_busy_cyc = 2;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        vx = '{2'b10, 7'h00, 7'h2A, 2'b10, 8'h00, 8'h00, 8'h5D, 1'b0, 1'b0, 1, 7'h2A, 1'b1, 8'h00, 8'h5D, 1'b0, 1'b0};
        run_txn(vx, "after rst");

        check("invariants", inv_err, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_i2c_req_arbiter
`default_nettype wire
